// File: rtl/rr_dispatch_collect_if.sv
// Handshake and unit-array bundle for rr_dispatch_collect.
// The master side is the request source, the downstream sink and the compute units.
interface rr_dispatch_collect_if #(
  parameter int unsigned ARG_W   = 16,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned N_UNITS = 4
) ();
  logic                       up_vld;
  logic                       up_rdy;
  logic [ARG_W-1:0]           up_data;
  logic [N_UNITS-1:0]         unit_start;
  logic [ARG_W-1:0]           unit_arg;
  logic [N_UNITS-1:0]         unit_done;
  logic [N_UNITS*RES_W-1:0]   unit_res;
  logic                       down_vld;
  logic                       down_rdy;
  logic [RES_W-1:0]           down_data;

  modport master (
    output up_vld, up_data, unit_done, unit_res, down_rdy,
    input  up_rdy, unit_start, unit_arg, down_vld, down_data
  );

  modport slave (
    input  up_vld, up_data, unit_done, unit_res, down_rdy,
    output up_rdy, unit_start, unit_arg, down_vld, down_data
  );
endinterface

// File: rtl/rr_dispatch_collect.sv
// Round-robin dispatcher over N_UNITS variable-latency units; results are
// collected per slot and returned downstream strictly in issue order.
module rr_dispatch_collect #(
  parameter int unsigned ARG_W   = 16,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned N_UNITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  rr_dispatch_collect_if.slave           bus,
  output logic [$clog2(N_UNITS+1)-1:0]   inflight,
  output logic                           err_spurious
);

  localparam int unsigned PtrW = $clog2(N_UNITS);
  localparam int unsigned CntW = $clog2(N_UNITS + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} slot_e;

  slot_e            slot_q [N_UNITS];
  slot_e            slot_d [N_UNITS];
  logic [RES_W-1:0] res_q  [N_UNITS];
  logic [RES_W-1:0] res_d  [N_UNITS];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             down_vld_q, down_vld_d;
  logic [RES_W-1:0] down_data_q, down_data_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic             err_q, err_d;

  logic             accept;
  logic             drain;
  logic [ARG_W-1:0] arg;
  logic [CntW-1:0]  busy_cnt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(N_UNITS - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_UNITS; i++) begin
        slot_q[i] <= StIdle;
        res_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      down_vld_q  <= 1'b0;
      down_data_q <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_UNITS; i++) begin
        slot_q[i] <= slot_d[i];
        res_q[i]  <= res_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      down_vld_q  <= down_vld_d;
      down_data_q <= down_data_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    down_vld_d  = down_vld_q;
    down_data_d = down_data_q;
    err_d       = err_q;
    busy_cnt    = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      slot_d[i] = slot_q[i];
      res_d[i]  = res_q[i];
      case (slot_q[i])
        StIdle: if (accept && (wr_ptr_q == PtrW'(i))) slot_d[i] = StBusy;
        StBusy: begin
          if (bus.unit_done[i]) begin
            slot_d[i] = StDone;
            res_d[i]  = bus.unit_res[i*RES_W +: RES_W];
          end
        end
        StDone: if (drain && (rd_ptr_q == PtrW'(i))) slot_d[i] = StIdle;
        default: slot_d[i] = StIdle;
      endcase
      // A done pulse for a slot that is not waiting on its unit is dropped but remembered.
      if (bus.unit_done[i] && (slot_q[i] != StBusy)) err_d = 1'b1;
      if (slot_d[i] != StIdle) busy_cnt = busy_cnt + CntW'(1);
    end

    if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);

    if (drain) begin
      down_vld_d  = 1'b1;
      down_data_d = res_q[rd_ptr_q];
      rd_ptr_d    = ptr_inc(rd_ptr_q);
    end else if (bus.down_rdy) begin
      down_vld_d  = 1'b0;
    end

    inflight_d = busy_cnt;
  end

  // Outputs and handshake decode
  always_comb begin
    arg            = bus.up_data;
    bus.up_rdy     = !rst && (slot_q[wr_ptr_q] == StIdle);
    accept         = bus.up_vld && bus.up_rdy;
    // Output register is free when empty or being consumed this cycle.
    drain          = (slot_q[rd_ptr_q] == StDone) && (!down_vld_q || bus.down_rdy);
    bus.unit_start = '0;
    if (accept) bus.unit_start[wr_ptr_q] = 1'b1;
    bus.unit_arg   = arg;
    bus.down_vld   = down_vld_q;
    bus.down_data  = down_data_q;
    inflight       = inflight_q;
    err_spurious   = err_q;
  end

endmodule

// File: tb/tb_rr_dispatch_collect.sv
// Bench for rr_dispatch_collect: behavioural unit models, an in-order scoreboard,
// a table of traffic vectors and directed multi-cycle sequences.
module tb_rr_dispatch_collect;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  typedef struct {
    int unsigned l0, l1, l2, l3;
    int unsigned n_req;
    int unsigned rdy_pct;
    logic [15:0] base;
    int unsigned exp_out;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] inflight;
  logic       err_spurious;

  rr_dispatch_collect_if #(.ARG_W(W), .RES_W(W), .N_UNITS(N)) bus ();

  rr_dispatch_collect #(.ARG_W(W), .RES_W(W), .N_UNITS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .inflight     (inflight),
    .err_spurious (err_spurious)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic [15:0] exp_q[$];

  bit          rdy_auto;
  bit          rnd_rdy;
  bit          man_rdy;
  int unsigned rdy_pct;
  int unsigned lat [N];
  logic [3:0]  m_done;
  logic [3:0]  spur_done;
  logic [15:0] m_arg [N];
  logic [15:0] m_res [N];
  int unsigned m_cnt [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [15:0] a);
    return a + 16'h1100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  assign bus.unit_done = m_done | spur_done;
  assign bus.down_rdy  = rdy_auto ? rnd_rdy : man_rdy;

  always_comb begin
    bus.unit_res = '0;
    for (int i = 0; i < N; i++) bus.unit_res[i*W +: W] = m_res[i];
  end

  // Non-pipelined unit models: result appears lat cycles after the start edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_cnt[i]  <= 0;
        m_done[i] <= 1'b0;
        m_res[i]  <= '0;
        m_arg[i]  <= '0;
      end else begin
        m_done[i] <= 1'b0;
        if (bus.unit_start[i]) begin
          m_cnt[i] <= lat[i];
          m_arg[i] <= bus.unit_arg;
        end else if (m_cnt[i] != 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_done[i] <= 1'b1;
            m_res[i]  <= f(m_arg[i]);
          end
        end
      end
    end
  end

  always @(negedge clk) rnd_rdy = ($urandom_range(99) < rdy_pct);

  // Scoreboard: push on accepted request, pop on delivered result.
  always begin
    logic [15:0] e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.up_vld && bus.up_rdy) exp_q.push_back(f(bus.up_data));
      if (bus.down_vld && bus.down_rdy) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got 0x%0h, expected no output at %0t",
                   bus.down_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {16'h0, bus.down_data}, {16'h0, e});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [15:0] d, output logic [3:0] st);
    bit ok;
    ok = 1'b0;
    st = '0;
    bus.up_vld  = 1'b1;
    bus.up_data = d;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (bus.up_rdy) begin
        ok = 1'b1;
        st = bus.unit_start;
      end
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no up_rdy, expected accept of 0x%0h", d);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok, c;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      c = (inflight == 0) && !bus.down_vld && (exp_q.size() == 0);
      @(negedge clk);
      if (c) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle_timeout: got inflight %0d, expected 0", name, inflight);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_lat(input int unsigned a, b, c, d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [4];
    logic [3:0]  st;
    bit          seen;
    int          n0;

    vecs[0] = '{6, 4, 8, 1, 4, 100, 16'h0100, 4};   // completion order 3,1,0,2
    vecs[1] = '{1, 1, 1, 1, 8, 100, 16'h0200, 8};
    vecs[2] = '{2, 5, 3, 1, 12, 50, 16'h0300, 12};
    vecs[3] = '{1, 3, 2, 4, 11, 30, 16'h0400, 11};

    rst = 1'b1; bus.up_vld = 1'b0; bus.up_data = '0;
    man_rdy = 1'b1; rdy_auto = 1'b0; rdy_pct = 100; spur_done = '0;
    set_lat(1, 1, 1, 1);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_up_rdy_low", bus.up_rdy, 0);
    chk("rst_down_vld", bus.down_vld, 0);
    chk("rst_inflight", inflight, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_up_rdy", bus.up_rdy, 1);
    chk("post_rst_start", bus.unit_start, 0);
    chk("post_rst_err", err_spurious, 0);
    chk("post_rst_down_data", bus.down_data, 0);
    @(negedge clk);

    // Single request, exact latency
    set_lat(3, 1, 1, 1);
    bus.up_vld = 1'b1; bus.up_data = 16'h0011;
    #1;
    chk("t1_start", bus.unit_start, 4'b0001);
    chk("t1_arg", bus.unit_arg, 16'h0011);
    chk("t1_inflight0", inflight, 0);
    @(negedge clk);
    bus.up_vld = 1'b0;
    #1;
    chk("t1_inflight1", inflight, 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.unit_done[0]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("t1_done_seen", seen, 1);
    chk("t1_no_early_vld", bus.down_vld, 0);
    @(negedge clk); #1;
    chk("t1_slot_done_vld", bus.down_vld, 0);
    chk("t1_slot_done_inflight", inflight, 1);
    @(negedge clk); #1;
    chk("t1_vld", bus.down_vld, 1);
    chk("t1_data", bus.down_data, 16'h1111);
    chk("t1_inflight_end", inflight, 0);
    @(negedge clk); #1;
    chk("t1_vld_clear", bus.down_vld, 0);
    @(negedge clk);

    // Table-driven traffic
    for (int v = 0; v < 4; v++) begin
      do_reset();
      set_lat(vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].l3);
      rdy_pct  = vecs[v].rdy_pct;
      rdy_auto = 1'b1;
      n0 = n_out;
      for (int k = 0; k < int'(vecs[v].n_req); k++) send(vecs[v].base + 16'(k * 'h123), st);
      bus.up_vld = 1'b0;
      wait_idle("vec");
      #1;
      chk("vec_count", n_out - n0, vecs[v].exp_out);
      chk("vec_inflight", inflight, 0);
      chk("vec_err", err_spurious, 0);
      chk("vec_up_rdy", bus.up_rdy, 1);
      @(negedge clk);
    end
    rdy_auto = 1'b0;
    man_rdy  = 1'b1;

    // Full: fifth request waits and wraps to unit 0
    do_reset();
    set_lat(10, 10, 10, 10);
    for (int k = 0; k < 4; k++) send(16'h0A00 + 16'(k), st);
    bus.up_vld = 1'b1; bus.up_data = 16'h0A04;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_full_rdy", bus.up_rdy, 0);
      chk("t3_full_inflight", inflight, 4);
      @(negedge clk);
    end
    send(16'h0A04, st);
    chk("t3_wrap_unit0", st, 4'b0001);
    bus.up_vld = 1'b0;
    wait_idle("t3");

    // Backpressure hold with two results ready
    set_lat(1, 1, 1, 1);
    man_rdy = 1'b0;
    send(16'h0B00, st);
    send(16'h0B01, st);
    bus.up_vld = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_hold_vld", bus.down_vld, 1);
      chk("t4_hold_data", bus.down_data, f(16'h0B00));
      @(negedge clk);
    end
    #1;
    chk("t4_second_done", inflight, 1);
    @(negedge clk);
    man_rdy = 1'b1;
    @(negedge clk); #1;
    chk("t4_next_vld", bus.down_vld, 1);
    chk("t4_next_data", bus.down_data, f(16'h0B01));
    @(negedge clk); #1;
    chk("t4_drained", bus.down_vld, 0);
    @(negedge clk);
    wait_idle("t4");

    // Spurious done on an idle slot
    spur_done = 4'b0100;
    @(negedge clk);
    spur_done = '0;
    #1;
    chk("t5_err", err_spurious, 1);
    chk("t5_no_vld", bus.down_vld, 0);
    chk("t5_inflight", inflight, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_err_sticky", err_spurious, 1);
    @(negedge clk);

    // Reset mid-operation
    set_lat(20, 20, 20, 20);
    for (int k = 0; k < 3; k++) send(16'h0C00 + 16'(k), st);
    bus.up_vld = 1'b0;
    #1;
    chk("t6_pre_inflight", inflight, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_up_rdy", bus.up_rdy, 1);
    chk("t6_down_vld", bus.down_vld, 0);
    chk("t6_inflight", inflight, 0);
    chk("t6_err_clear", err_spurious, 0);
    @(negedge clk);
    set_lat(2, 2, 2, 2);
    send(16'h0D00, st);
    chk("t6_unit0", st, 4'b0001);
    bus.up_vld = 1'b0;
    wait_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
